// File: rtl/gun_dispatch.sv
// ============================================================================
// Module   : gun_dispatch
// Brief    : Operand FIFO, job launcher, hang watchdog and result collector
//            for the gun compute core (y = a*b + a^3, 8-bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module gun_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_a_bi,
    input  logic [7:0] in_b_bi,
    output logic       core_start_o,
    output logic [7:0] core_a_bo,
    output logic [7:0] core_b_bo,
    input  logic       core_busy_i,
    input  logic [7:0] core_y_bi,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_y_bo,
    output logic [7:0] out_a_bo,
    output logic [7:0] out_b_bo,
    output logic [2:0] fifo_count_o,
    output logic       timeout_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_full    = CW'(DEPTH);
    localparam logic [7:0]    c_wd_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_IDLE  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [7:0]      r_mem_a [DEPTH];
    logic [7:0]      r_mem_b [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_wd;

    logic            r_out_valid;
    logic [7:0]      r_out_y;
    logic [7:0]      r_out_a;
    logic [7:0]      r_out_b;
    logic [7:0]      r_core_a;
    logic [7:0]      r_core_b;
    logic            r_timeout;

    logic            w_push;
    logic            w_pop;
    logic            w_launch;
    logic            w_capture;
    logic            w_timeout_hit;
    logic            w_wd_hit;

    assign in_ready_o   = (r_count != c_full);
    assign w_push       = in_valid_i & in_ready_o;
    assign w_wd_hit     = (r_wd == c_wd_last);

    // The core takes its reset from our start line, so a dispatcher reset
    // also restarts the core with zero operands.
    assign core_start_o = rst_i | (r_state == S_START);
    assign core_a_bo    = r_core_a;
    assign core_b_bo    = r_core_b;
    assign out_valid_o  = r_out_valid;
    assign out_y_bo     = r_out_y;
    assign out_a_bo     = r_out_a;
    assign out_b_bo     = r_out_b;
    assign fifo_count_o = 3'(r_count);
    assign timeout_o    = r_timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_FLUSH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_launch      = 1'b0;
        w_capture     = 1'b0;
        w_pop         = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_FLUSH: begin
                if (!core_busy_i) begin
                    w_next = S_IDLE;
                end else if (w_wd_hit) begin
                    w_next        = S_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            S_IDLE: begin
                // Only launch when the output slot is free, so a capture can
                // never collide with an unconsumed result.
                if ((r_count != '0) && !r_out_valid) begin
                    w_next   = S_START;
                    w_launch = 1'b1;
                end
            end
            S_START: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (!core_busy_i) begin
                    w_next    = S_IDLE;
                    w_capture = 1'b1;
                    w_pop     = 1'b1;
                end else if (w_wd_hit) begin
                    w_next        = S_IDLE;
                    w_timeout_hit = 1'b1;
                    w_pop         = 1'b1;
                end
            end
            default: begin
                w_next = S_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a_bi;
            r_mem_b[r_wr_ptr] <= in_b_bi;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Watchdog runs in FLUSH and WAIT; it is zeroed while idle and on launch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wd <= '0;
        end else if ((r_state == S_FLUSH) || (r_state == S_WAIT)) begin
            r_wd <= r_wd + 8'd1;
        end else begin
            r_wd <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end
    end

    // Operands are latched on the launch decision and held for the whole job
    // because the core re-reads them while computing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_core_a <= '0;
            r_core_b <= '0;
        end else if (w_launch) begin
            r_core_a <= r_mem_a[r_rd_ptr];
            r_core_b <= r_mem_b[r_rd_ptr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_y     <= core_y_bi;
            r_out_a     <= r_core_a;
            r_out_b     <= r_core_b;
        end else if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gun_dispatch.sv
// ============================================================================
// Module   : tb_gun_dispatch
// Brief    : Directed self-checking bench for gun_dispatch with a core model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gun_dispatch;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       core_start;
    logic [7:0] core_a;
    logic [7:0] core_b;
    logic       core_busy;
    logic [7:0] core_y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [2:0] fifo_count;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gun_dispatch #(.DEPTH(4), .TIMEOUT(20)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_a_bi      (in_a),
        .in_b_bi      (in_b),
        .core_start_o (core_start),
        .core_a_bo    (core_a),
        .core_b_bo    (core_b),
        .core_busy_i  (core_busy),
        .core_y_bi    (core_y),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_y_bo     (out_y),
        .out_a_bo     (out_a),
        .out_b_bo     (out_b),
        .fifo_count_o (fifo_count),
        .timeout_o    (timeout)
    );

    // Core model: start acts as its reset; it computes from a_in/b_in as
    // they are at the end of the job, so unstable operands give wrong y.
    logic m_busy = 1'b0;
    logic m_stuck = 1'b0;
    logic [7:0] m_y = 8'd0;
    int m_cnt = 0;
    assign core_busy = m_busy;
    assign core_y    = m_y;

    always @(posedge clk) begin
        if (core_start) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT;
        end else if (m_busy && !m_stuck) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_y    <= core_a * core_b + core_a * core_a * core_a;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 80) begin
            tick();
            n++;
        end
        chk(tag, {15'd0, out_valid}, 16'd1);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!core_start && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {15'd0, core_start}, 16'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic seen_valid;
        logic seen_start;
        logic stable;
        int   n;

        rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;

        // Reset held two cycles, then FLUSH drains the dummy job.
        tick();
        tick();
        chk("rst_core_start", {15'd0, core_start}, 16'd1);
        chk("rst_out_valid",  {15'd0, out_valid}, 16'd0);
        chk("rst_in_ready",   {15'd0, in_ready}, 16'd1);
        chk("rst_fifo_count", {13'd0, fifo_count}, 16'd0);
        chk("rst_core_a",     {8'd0, core_a}, 16'd0);
        chk("rst_timeout",    {15'd0, timeout}, 16'd0);
        rst = 1'b0;
        seen_valid = 1'b0;
        seen_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_valid |= out_valid;
            seen_start |= core_start;
        end
        chk("flush_no_valid", {15'd0, seen_valid}, 16'd0);
        chk("flush_no_start", {15'd0, seen_start}, 16'd0);
        chk("flush_count",    {13'd0, fifo_count}, 16'd0);

        // Single job (2,3) -> 14 with operands held through WAIT.
        push(8'd2, 8'd3);
        wait_start("j1_start");
        chk("j1_core_a", {8'd0, core_a}, 16'd2);
        chk("j1_core_b", {8'd0, core_b}, 16'd3);
        stable = 1'b1;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
            if (!out_valid && (core_a !== 8'd2 || core_b !== 8'd3)) stable = 1'b0;
        end
        chk("j1_ops_stable", {15'd0, stable}, 16'd1);
        chk("j1_valid", {15'd0, out_valid}, 16'd1);
        chk("j1_y", {8'd0, out_y}, 16'd14);
        chk("j1_a", {8'd0, out_a}, 16'd2);
        chk("j1_b", {8'd0, out_b}, 16'd3);
        consume();
        chk("j1_cleared", {15'd0, out_valid}, 16'd0);

        // Four back-to-back pushes with the consumer stalled.
        push(8'd5, 8'd7);
        push(8'd3, 8'd4);
        push(8'd6, 8'd1);
        push(8'd1, 8'd1);
        chk("full_count", {13'd0, fifo_count}, 16'd4);
        chk("full_ready", {15'd0, in_ready}, 16'd0);
        wait_valid("r160_valid");
        chk("r160_y", {8'd0, out_y}, 16'd160);
        chk("r160_a", {8'd0, out_a}, 16'd5);
        chk("r160_b", {8'd0, out_b}, 16'd7);
        chk("after_pop_count", {13'd0, fifo_count}, 16'd3);
        chk("after_pop_ready", {15'd0, in_ready}, 16'd1);

        // Stalled consumer: outputs hold and nothing new launches.
        stable = 1'b1;
        seen_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_y !== 8'd160 || out_a !== 8'd5 || out_b !== 8'd7) stable = 1'b0;
            seen_start |= core_start;
        end
        chk("hold_stable", {15'd0, stable}, 16'd1);
        chk("hold_no_start", {15'd0, seen_start}, 16'd0);
        chk("hold_count", {13'd0, fifo_count}, 16'd3);
        consume();

        wait_valid("r39_valid");
        chk("r39_y", {8'd0, out_y}, 16'd39);
        chk("r39_a", {8'd0, out_a}, 16'd3);
        consume();
        wait_valid("r222_valid");
        chk("r222_y", {8'd0, out_y}, 16'd222);
        chk("r222_b", {8'd0, out_b}, 16'd1);
        consume();
        wait_valid("r2_valid");
        chk("r2_y", {8'd0, out_y}, 16'd2);
        consume();
        chk("drain_count", {13'd0, fifo_count}, 16'd0);

        // Core hang: watchdog fires after 20 WAIT cycles, entry dropped.
        m_stuck = 1'b1;
        push(8'd9, 8'd9);
        wait_start("hang_start");
        n = 0;
        seen_valid = 1'b0;
        while (!timeout && n < 40) begin
            tick();
            n++;
            seen_valid |= out_valid;
        end
        chk("hang_timeout", {15'd0, timeout}, 16'd1);
        chk("hang_latency", {15'd0, (n >= 20 && n <= 21)}, 16'd1);
        chk("hang_no_valid", {15'd0, seen_valid}, 16'd0);
        chk("hang_popped", {13'd0, fifo_count}, 16'd0);
        m_stuck = 1'b0;
        repeat (5) tick();
        push(8'd2, 8'd3);
        wait_valid("post_hang_valid");
        chk("post_hang_y", {8'd0, out_y}, 16'd14);
        chk("timeout_sticky", {15'd0, timeout}, 16'd1);
        consume();

        // Reset in the middle of a job: result lost, FLUSH, then recovery.
        push(8'd5, 8'd7);
        wait_start("mid_start");
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_start", {15'd0, core_start}, 16'd1);
        chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_count", {13'd0, fifo_count}, 16'd0);
        chk("mid_rst_timeout", {15'd0, timeout}, 16'd0);
        tick();
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_valid |= out_valid;
        end
        chk("mid_no_result", {15'd0, seen_valid}, 16'd0);
        push(8'd2, 8'd3);
        wait_valid("recover_valid");
        chk("recover_y", {8'd0, out_y}, 16'd14);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
